sensor_cond: RTL and testbench
==============================

SENSOR_COND -- requirements
Module: sensor_cond

Interface
REQ-001 Parameter WIN_BITS, default 24, cadence measurement window is 2^WIN_BITS clk cycles.
REQ-002 Parameter DEB_CYC, default 16, consecutive stable cycles required to accept a pedal-sensor level change (DEB_CYC >= 2).
REQ-003 Parameter AVG_SHIFT, default 4, exponential torque average weight is 1/2^AVG_SHIFT.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cadence  input  1  raw pedal-magnet sensor, asynchronous, may bounce.
REQ-007 torque  input  12  unsigned crank torque sample, synchronous to clk.
REQ-008 avg_torque  output  12  filtered torque, feeds desired-drive avg_torque.
REQ-009 cadence_vec  output  5  pedal rises per window, saturating, feeds desired-drive cadence_vec.
REQ-010 not_pedaling  output  1  high when rider is not pedaling.
REQ-011 avg_upd  output  1  one-cycle pulse in the cycle avg_torque takes a new value.

Function
REQ-012 cadence passes through a 2-flop synchronizer before any use.
REQ-013 Debounce: filtered level changes only after the synchronized level differs from it for DEB_CYC consecutive cycles; any agreeing cycle restarts the count at 0.
REQ-014 cad_rise is a one-cycle pulse in the cycle after the filtered level goes 0->1; latency from a clean raw rising edge to cad_rise is 2+DEB_CYC+1 cycles.
REQ-015 Window counter is WIN_BITS wide, free-running, wraps from all-ones to 0.
REQ-016 Rise counter is 5 bits, increments on cad_rise, saturates at 31.
REQ-017 In the terminal window cycle (counter all-ones): cadence_vec <= rise count plus that cycle's cad_rise (saturated at 31); rise counter <= 0.
REQ-018 cad_rise in the terminal cycle counts in the closing window, never the next.
REQ-019 At each window close, not_pedaling <= 1 if the new cadence_vec < 2, else 0; otherwise it holds.
REQ-020 Accumulator is 12+AVG_SHIFT bits; on cad_rise with not_pedaling = 0: acc <= acc - (acc >> AVG_SHIFT) + torque, torque sampled that same cycle.
REQ-021 The accumulator is bounded by 4095 * 2^AVG_SHIFT; the update cannot overflow and needs no saturation logic.
REQ-022 avg_torque = acc >> AVG_SHIFT, registered; it and avg_upd (pulse) update one cycle after the accumulating cad_rise.
REQ-023 While not_pedaling = 1: acc, avg_torque forced to 0, cad_rise ignored for averaging, avg_upd held 0.
REQ-024 Counting of rises continues regardless of not_pedaling so pedaling is re-detected at the next window close.

Reset
REQ-025 rst asserted: avg_torque = 0, cadence_vec = 0, not_pedaling = 1, avg_upd = 0, all counters, debounce state and synchronizer flops = 0, on the next clk edge.
REQ-026 rst mid-window discards partial rise count and accumulator; window restarts at 0 after release.

Structure
REQ-027 Shared package holds default WIN_BITS, DEB_CYC, AVG_SHIFT, and the not-pedaling threshold constant 2.
REQ-028 One sub-module cadence_filt contains synchronizer, debounce and rise-pulse generation; sensor_cond instantiates it once.

Verification (WIN_BITS=8, DEB_CYC=4, AVG_SHIFT=4 unless stated)
REQ-029 Assert rst 2 cycles -> avg_torque=0, cadence_vec=0, not_pedaling=1, avg_upd=0.
REQ-030 cadence high 3 cycles then low -> no cad_rise; high 10 cycles -> exactly one cad_rise, 7 cycles after the raw edge.
REQ-031 cadence period 32 (16 high/16 low) -> cadence_vec=8 and not_pedaling=0 after the first full 256-cycle window.
REQ-032 Pedaling as above, torque=0x800 -> first avg_upd gives avg_torque=0x080; after 100 updates avg_torque within 0x7F0..0x800.
REQ-033 cadence held low after pedaling -> next window close: cadence_vec=0, not_pedaling=1, avg_torque=0, no avg_upd.
REQ-034 WIN_BITS=9, cadence period 10 -> cadence_vec=31 (saturated); rise placed in terminal cycle counted in closing window.

Source files
------------

// File: rtl/sensor_cond_pkg.sv
// rtl/sensor_cond_pkg.sv - shared defaults and helpers for pedal sensor conditioning
package sensor_cond_pkg;

    localparam int DEF_WIN_BITS  = 24;
    localparam int DEF_DEB_CYC   = 16;
    localparam int DEF_AVG_SHIFT = 4;

    localparam int TORQUE_W = 12;
    localparam int CAD_W    = 5;

    typedef logic [TORQUE_W-1:0] torque_t;
    typedef logic [CAD_W-1:0]    cad_cnt_t;

    // Fewer rises than this in one window means the rider is not pedaling.
    localparam cad_cnt_t NP_THRESH = 5'd2;
    localparam cad_cnt_t CAD_MAX   = 5'd31;

    function automatic cad_cnt_t sat_inc(input cad_cnt_t cnt, input logic inc);
        if (!inc || cnt == CAD_MAX) begin
            return cnt;
        end
        return cnt + 5'd1;
    endfunction

endpackage

// File: rtl/sensor_cond_cadence_filt.sv
// rtl/sensor_cond_cadence_filt.sv - pedal sensor synchronizer, debounce and rise pulse
module cadence_filt #(
    parameter int DEB_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic cadence,
    output logic cad_rise
);

    localparam int CW = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;

    logic          sync_meta;
    logic          sync_lvl;
    logic          filt_lvl;
    logic          filt_prev;
    logic [CW-1:0] deb_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_lvl  <= 1'b0;
            filt_lvl  <= 1'b0;
            filt_prev <= 1'b0;
            deb_cnt   <= '0;
            cad_rise  <= 1'b0;
        end else begin
            sync_meta <= cadence;
            sync_lvl  <= sync_meta;
            filt_prev <= filt_lvl;
            cad_rise  <= filt_lvl & ~filt_prev;
            // The DEB_CYC-th consecutive disagreeing cycle flips the filtered level.
            if (sync_lvl == filt_lvl) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CW'(DEB_CYC - 1)) begin
                filt_lvl <= sync_lvl;
                deb_cnt  <= '0;
            end else begin
                deb_cnt <= deb_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sensor_cond.sv
// rtl/sensor_cond.sv - cadence measurement and pedal-synchronous torque averaging
module sensor_cond
    import sensor_cond_pkg::*;
#(
    parameter int WIN_BITS  = DEF_WIN_BITS,
    parameter int DEB_CYC   = DEF_DEB_CYC,
    parameter int AVG_SHIFT = DEF_AVG_SHIFT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cadence,
    input  logic [11:0] torque,
    output logic [11:0] avg_torque,
    output logic [4:0]  cadence_vec,
    output logic        not_pedaling,
    output logic        avg_upd
);

    localparam int ACC_W = TORQUE_W + AVG_SHIFT;

    logic                cad_rise;
    logic [WIN_BITS-1:0] win_cnt;
    logic                win_end;
    cad_cnt_t            rise_cnt;
    cad_cnt_t            rise_total;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_next;

    cadence_filt #(
        .DEB_CYC (DEB_CYC)
    ) u_filt (
        .clk      (clk),
        .rst      (rst),
        .cadence  (cadence),
        .cad_rise (cad_rise)
    );

    assign win_end    = &win_cnt;
    // A rise landing in the terminal cycle belongs to the window being closed.
    assign rise_total = sat_inc(rise_cnt, cad_rise);
    assign acc_next   = acc - (acc >> AVG_SHIFT) + {{AVG_SHIFT{1'b0}}, torque};

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt      <= '0;
            rise_cnt     <= '0;
            cadence_vec  <= '0;
            not_pedaling <= 1'b1;
        end else begin
            win_cnt <= win_cnt + WIN_BITS'(1);
            if (win_end) begin
                cadence_vec  <= rise_total;
                rise_cnt     <= '0;
                not_pedaling <= (rise_total < NP_THRESH);
            end else begin
                rise_cnt <= rise_total;
            end
        end
    end

    // Bounded by 4095 * 2^AVG_SHIFT, so the update cannot overflow ACC_W bits.
    always_ff @(posedge clk) begin
        if (rst || not_pedaling) begin
            acc        <= '0;
            avg_torque <= '0;
            avg_upd    <= 1'b0;
        end else begin
            avg_upd <= cad_rise;
            if (cad_rise) begin
                acc        <= acc_next;
                avg_torque <= acc_next[ACC_W-1:AVG_SHIFT];
            end
        end
    end

endmodule

// File: tb/tb_sensor_cond.sv
// tb/tb_sensor_cond.sv - scoreboard bench for sensor_cond
module tb_sensor_cond;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cad_a = 1'b0;
    logic        cad_b = 1'b0;
    logic [11:0] torque = 12'h800;
    logic [11:0] avg_a, avg_b;
    logic [4:0]  vec_a, vec_b;
    logic        np_a, np_b, upd_a, upd_b;

    always #5 clk = ~clk;

    sensor_cond #(.WIN_BITS(8), .DEB_CYC(4), .AVG_SHIFT(4)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .cadence      (cad_a),
        .torque       (torque),
        .avg_torque   (avg_a),
        .cadence_vec  (vec_a),
        .not_pedaling (np_a),
        .avg_upd      (upd_a)
    );

    sensor_cond #(.WIN_BITS(9), .DEB_CYC(4), .AVG_SHIFT(4)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .cadence      (cad_b),
        .torque       (torque),
        .avg_torque   (avg_b),
        .cadence_vec  (vec_b),
        .not_pedaling (np_b),
        .avg_upd      (upd_b)
    );

    typedef struct packed {
        logic [4:0] vec;
        logic       np;
    } win_t;

    typedef struct packed {
        logic [11:0] lo;
        logic [11:0] hi;
    } avg_t;

    win_t exp_win_a[$];
    win_t exp_win_b[$];
    avg_t exp_avg[$];
    win_t wa, wb;
    avg_t ea;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_upd    = 0;
    int rises;
    int lat;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Bench-side window position: cycles elapsed since the last reset edge.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (!rst && cyc > 0 && cyc % 256 == 0 && exp_win_a.size() > 0) begin
            wa = exp_win_a.pop_front();
            chk($sformatf("win_a_vec@%0d", cyc), vec_a, wa.vec);
            chk($sformatf("win_a_np@%0d", cyc), np_a, wa.np);
        end
        if (!rst && cyc > 0 && cyc % 512 == 0 && exp_win_b.size() > 0) begin
            wb = exp_win_b.pop_front();
            chk($sformatf("win_b_vec@%0d", cyc), vec_b, wb.vec);
            chk($sformatf("win_b_np@%0d", cyc), np_b, wb.np);
        end
    end

    always @(negedge clk) begin
        if (!rst && upd_a) begin
            n_upd++;
            n_checks++;
            if (exp_avg.size() == 0) begin
                $display("FAIL avg_upd_unexpected@%0d: got avg_torque %h, required no update", cyc, avg_a);
            end else begin
                ea = exp_avg.pop_front();
                if (avg_a >= ea.lo && avg_a <= ea.hi) n_pass++;
                else $display("FAIL avg_torque_upd%0d: got %h required %h..%h", n_upd, avg_a, ea.lo, ea.hi);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_avg_torque", avg_a, 0);
        chk("rst_cadence_vec", vec_a, 0);
        chk("rst_not_pedaling", np_a, 1);
        chk("rst_avg_upd", upd_a, 0);
        @(negedge clk) rst = 1'b0;

        // Short glitch: three cycles high must not produce a rise.
        repeat (3) @(posedge clk);
        #1 cad_a = 1'b1;
        rises = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) cad_a = 1'b0;
            if (dut_a.cad_rise) rises++;
        end
        chk("glitch_rises", rises, 0);

        cad_a = 1'b1;
        rises = 0;
        lat   = 0;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk);
            #1;
            if (i == 10) cad_a = 1'b0;
            if (dut_a.cad_rise) begin
                rises++;
                if (lat == 0) lat = i;
            end
        end
        chk("clean_rise_latency", lat, 7);
        chk("clean_rise_count", rises, 1);

        // Mid-window reset: the partial count above must be discarded.
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        for (int k = 1; k <= 14; k++) exp_win_a.push_back('{vec: 5'd8, np: 1'b0});
        exp_win_a.push_back('{vec: 5'd0, np: 1'b1});
        exp_win_b.push_back('{vec: 5'd31, np: 1'b0});
        exp_win_b.push_back('{vec: 5'd2, np: 1'b0});
        exp_win_b.push_back('{vec: 5'd0, np: 1'b1});
        exp_avg.push_back('{lo: 12'h080, hi: 12'h080});
        exp_avg.push_back('{lo: 12'h0F8, hi: 12'h0F8});
        exp_avg.push_back('{lo: 12'h168, hi: 12'h168});
        for (int k = 4; k <= 99; k++) exp_avg.push_back('{lo: 12'h168, hi: 12'h800});
        for (int k = 100; k <= 104; k++) exp_avg.push_back('{lo: 12'h7F0, hi: 12'h800});

        while (cyc < 3845) begin
            cad_a = (cyc < 3584) && (cyc % 32 < 16);
            cad_b = (cyc < 500 && cyc % 10 < 5) || (cyc >= 600 && cyc < 610)
                    || (cyc >= 1016 && cyc < 1026);
            if (cyc == 3842) begin
                chk("stopped_avg_torque", avg_a, 0);
                chk("stopped_avg_upd", upd_a, 0);
            end
            @(negedge clk);
        end

        chk("avg_queue_left", exp_avg.size(), 0);
        chk("win_a_queue_left", exp_win_a.size(), 0);
        chk("win_b_queue_left", exp_win_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
